// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch/decode definitions: opcodes, bubble instruction,
// fetch state encoding and the IF/ID bundle.
package wisc_defs;

    localparam logic [3:0] HLT_OP = 4'hF;
    localparam logic [3:0] JAL_OP = 4'hD;
    localparam logic [3:0] JR_OP  = 4'hE;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        vld;
    } if_id_t;

    function automatic logic [15:0] pc_inc(input logic [15:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch stage bus: hazard/redirect inputs, instruction memory port,
// IF/ID outputs and status.
interface if_fetch_unit_if;

    logic        stall;
    logic        j_ctrl;
    logic [15:0] j_pc;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        instr_vld;
    logic        fetch_halted;
    logic [15:0] flush_cnt;

    modport master (
        input  stall, j_ctrl, j_pc, im_instr,
        output im_addr, im_rd_en, instr, pc,
        output instr_vld, fetch_halted, flush_cnt
    );

    modport slave (
        output stall, j_ctrl, j_pc, im_instr,
        input  im_addr, im_rd_en, instr, pc,
        input  instr_vld, fetch_halted, flush_cnt
    );

endinterface

// File: rtl/if_fetch_unit_preg.sv
// IF/ID pipeline register; hold beats flush beats load.
module if_id_preg #(
    parameter logic [15:0] NOP_INSTR = wisc_defs::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              load,
    input  wisc_defs::if_id_t d,
    output wisc_defs::if_id_t q
);
    import wisc_defs::*;

    if_id_t bubble;
    assign bubble = '{instr: NOP_INSTR, pc: 16'h0000, vld: 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= bubble;
        end else if (hold) begin
            q <= q;
        end else if (flush) begin
            q <= bubble;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, next-PC selection, halt FSM,
// jump flush counter and the IF/ID register.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = wisc_defs::NOP_INSTR,
    parameter logic [3:0]  HLT_OP    = wisc_defs::HLT_OP
) (
    input logic            clk,
    input logic            rst_n,
    if_fetch_unit_if.master bus
);
    import wisc_defs::*;

    fetch_state_t state;
    logic [15:0]  pc_q;
    logic [15:0]  flush_cnt;
    logic         is_hlt;
    logic         flush;
    if_id_t       fetched;
    if_id_t       if_id;

    assign is_hlt = (bus.im_instr[15:12] == HLT_OP);
    assign flush  = bus.j_ctrl || (state == HALT);

    assign fetched = '{
        instr: bus.im_instr,
        pc:    pc_inc(pc_q),
        vld:   1'b1
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            state     <= RUN;
            flush_cnt <= 16'h0000;
        end else if (bus.stall) begin
            pc_q      <= pc_q;
        end else if (bus.j_ctrl) begin
            // A resolved jump also squashes a speculatively fetched HLT.
            pc_q  <= bus.j_pc;
            state <= RUN;
            if (flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end else if (state == RUN) begin
            if (is_hlt) begin
                state <= HALT;
            end else begin
                pc_q <= pc_inc(pc_q);
            end
        end
    end

    if_id_preg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_preg (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (bus.stall),
        .flush(flush),
        .load (state == RUN),
        .d    (fetched),
        .q    (if_id)
    );

    assign bus.im_addr      = pc_q;
    assign bus.im_rd_en     = (state == RUN) && !bus.stall;
    assign bus.instr        = if_id.instr;
    assign bus.pc           = if_id.pc;
    assign bus.instr_vld    = if_id.vld;
    assign bus.fetch_halted = (state == HALT);
    assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, stall, jump,
// halt and its squash cases, PC wrap and asynchronous reset.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    assign bus.im_instr = mem[bus.im_addr[7:0]];

    if_fetch_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.stall  = 1'b0;
        bus.j_ctrl = 1'b0;
        bus.j_pc   = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [65:0] got, exp;
        do_reset();
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld,
               bus.fetch_halted, bus.flush_cnt};
        exp = {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset: got %h expected %h", got, exp);
        end
        checks++;
        if (bus.im_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_rd_en: got %b expected 1", bus.im_rd_en);
        end
    endtask

    task automatic test_seq();
        logic [48:0] got, exp;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step(1);
            got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld};
            exp = {16'(k), 16'h0100 + 16'(k - 1), 16'(k), 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL seq[%0d]: got %h expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [49:0] got, exp;
        do_reset();
        step(2);
        bus.stall = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld, bus.im_rd_en};
            exp = {16'h0002, 16'h0101, 16'h0002, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall[%0d]: got %h expected %h", k, got, exp);
            end
            step(1);
        end
        bus.stall = 1'b0;
        step(1);
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld, bus.im_rd_en};
        exp = {16'h0003, 16'h0102, 16'h0003, 1'b1, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_resume: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_jump();
        logic [64:0] got, exp;
        do_reset();
        step(5);
        bus.j_ctrl = 1'b1;
        bus.j_pc   = 16'h0040;
        step(1);
        bus.j_ctrl = 1'b0;
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld, bus.flush_cnt};
        exp = {16'h0040, 16'h0000, 16'h0000, 1'b0, 16'h0001};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL jump_bubble: got %h expected %h", got, exp);
        end
        step(1);
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld, bus.flush_cnt};
        exp = {16'h0041, 16'h0140, 16'h0041, 1'b1, 16'h0001};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL jump_target: got %h expected %h", got, exp);
        end
        bus.j_ctrl = 1'b1;
        bus.j_pc   = 16'h0010;
        step(1);
        bus.j_ctrl = 1'b0;
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld, bus.flush_cnt};
        exp = {16'h0010, 16'h0000, 16'h0000, 1'b0, 16'h0002};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL jump_second: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_jump_stall();
        logic [64:0] got, exp;
        do_reset();
        step(3);
        bus.stall  = 1'b1;
        bus.j_ctrl = 1'b1;
        bus.j_pc   = 16'h0020;
        step(1);
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld, bus.flush_cnt};
        exp = {16'h0003, 16'h0102, 16'h0003, 1'b1, 16'h0000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL jump_stall_hold: got %h expected %h", got, exp);
        end
        bus.stall = 1'b0;
        step(1);
        bus.j_ctrl = 1'b0;
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld, bus.flush_cnt};
        exp = {16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0001};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL jump_stall_release: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_halt();
        logic [50:0] got, exp;
        do_reset();
        mem[7] = 16'hF000;
        step(7);
        step(1);
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld,
               bus.fetch_halted, bus.im_rd_en};
        exp = {16'h0007, 16'hF000, 16'h0008, 1'b1, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL halt_fetch: got %h expected %h", got, exp);
        end
        for (int k = 0; k < 3; k++) begin
            step(1);
            got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld,
                   bus.fetch_halted, bus.im_rd_en};
            exp = {16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got %h expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_halt_squash1();
        logic [32:0] got, exp;
        do_reset();
        mem[7] = 16'hF000;
        step(8);
        bus.j_ctrl = 1'b1;
        bus.j_pc   = 16'h0010;
        step(1);
        bus.j_ctrl = 1'b0;
        got = {bus.im_addr, bus.fetch_halted, bus.flush_cnt};
        exp = {16'h0010, 1'b0, 16'h0001};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL halt_squash1: got %h expected %h", got, exp);
        end
        step(1);
        got = {bus.im_addr, bus.fetch_halted, bus.instr};
        exp = {16'h0011, 1'b0, 16'h0110};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL halt_squash1_run: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_halt_squash2();
        logic [16:0] got, exp;
        do_reset();
        mem[7] = 16'hF000;
        step(7);
        bus.j_ctrl = 1'b1;
        bus.j_pc   = 16'h0030;
        step(1);
        bus.j_ctrl = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = {bus.im_addr, bus.fetch_halted};
            exp = {16'h0030 + 16'(k), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL halt_squash2[%0d]: got %h expected %h", k, got, exp);
            end
            step(1);
        end
    endtask

    task automatic test_wrap_reset();
        logic [65:0] got, exp;
        do_reset();
        bus.j_ctrl = 1'b1;
        bus.j_pc   = 16'hFFFF;
        step(1);
        bus.j_ctrl = 1'b0;
        checks++;
        if (bus.im_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_pre: got %h expected ffff", bus.im_addr);
        end
        step(1);
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld,
               bus.fetch_halted, bus.flush_cnt};
        exp = {16'h0000, 16'h01FF, 16'h0000, 1'b1, 1'b0, 16'h0001};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap: got %h expected %h", got, exp);
        end
        step(2);
        rst_n = 1'b0;
        #1;
        got = {bus.im_addr, bus.instr, bus.pc, bus.instr_vld,
               bus.fetch_halted, bus.flush_cnt};
        exp = {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", got, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_jump();
        test_jump_stall();
        test_halt();
        test_halt_squash1();
        test_halt_squash2();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
